exception_vector_fetch: RTL and testbench

//   Initiator that drives the 3-bit address-mux selector during exception entry. Accepts
//   one of three exception causes, saves EPC and steers the memory address to vector

---
 rtl/exception_vector_fetch.sv | 162 ++++++++++++++++
 tb/tb_exception_vector_fetch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/exception_vector_fetch.sv
// Exception-entry initiator: latches cause and EPC, steers the address mux to the
// matching vector slot, waits out memory latency, then loads PC with the handler byte.
module exception_vector_fetch #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  addr_sel,
  output logic        epc_write,
  output logic [31:0] epc_value,
  output logic        pc_write,
  output logic [31:0] pc_value,
  output logic        busy,
  output logic        exc_ack
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BYTE_W = 8;

  localparam logic [SEL_W-1:0] SEL_PC   = 3'b000;
  localparam logic [SEL_W-1:0] SEL_V253 = 3'b010;
  localparam logic [SEL_W-1:0] SEL_V254 = 3'b011;
  localparam logic [SEL_W-1:0] SEL_V255 = 3'b100;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  // ACCEPT is the cycle in which the cause and EPC sit registered before the
  // address is driven; REQ/CAPTURE/DONE then line up with the visible outputs.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_REQ,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    vec_q, vec_d;
  logic [SEL_W-1:0]    addr_sel_q, addr_sel_d;
  logic                epc_write_q, epc_write_d;
  logic                pc_write_q, pc_write_d;
  logic                exc_ack_q, exc_ack_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   epc_value_q, epc_value_d;
  logic [DATA_W-1:0]   pc_value_q, pc_value_d;

  logic                any_req_c;
  logic [SEL_W-1:0]    req_vec_c;
  logic                unused_mem_hi;

  // Only the low byte of the vector slot is the handler address.
  assign unused_mem_hi = ^mem_data_in[DATA_W-1:BYTE_W];

  assign any_req_c = exc_opcode | exc_ovf | exc_div0;

  always_comb begin
    req_vec_c = SEL_V255;
    if (exc_opcode) begin
      req_vec_c = SEL_V253;
    end else if (exc_ovf) begin
      req_vec_c = SEL_V254;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vec_q       <= SEL_PC;
      addr_sel_q  <= SEL_PC;
      epc_write_q <= 1'b0;
      pc_write_q  <= 1'b0;
      exc_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      epc_value_q <= '0;
      pc_value_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      addr_sel_q  <= addr_sel_d;
      epc_write_q <= epc_write_d;
      pc_write_q  <= pc_write_d;
      exc_ack_q   <= exc_ack_d;
      busy_q      <= busy_d;
      epc_value_q <= epc_value_d;
      pc_value_q  <= pc_value_d;
    end
  end

  // Next-state logic; each branch produces the outputs for the state being entered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    epc_value_d = epc_value_q;
    pc_value_d  = pc_value_q;
    addr_sel_d  = SEL_PC;
    epc_write_d = 1'b0;
    pc_write_d  = 1'b0;
    exc_ack_d   = 1'b0;
    busy_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          state_d     = S_ACCEPT;
          vec_d       = req_vec_c;
          epc_value_d = pc_in - DATA_W'(4);
          busy_d      = 1'b1;
        end
      end
      S_ACCEPT: begin
        state_d     = S_REQ;
        cnt_d       = '0;
        addr_sel_d  = vec_q;
        epc_write_d = 1'b1;
        busy_d      = 1'b1;
      end
      S_REQ: begin
        addr_sel_d = vec_q;
        busy_d     = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        state_d    = S_DONE;
        pc_value_d = {(DATA_W - BYTE_W)'(0), mem_data_in[BYTE_W-1:0]};
        pc_write_d = 1'b1;
        exc_ack_d  = 1'b1;
        busy_d     = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign addr_sel  = addr_sel_q;
  assign epc_write = epc_write_q;
  assign epc_value = epc_value_q;
  assign pc_write  = pc_write_q;
  assign pc_value  = pc_value_q;
  assign busy      = busy_q;
  assign exc_ack   = exc_ack_q;

endmodule

// File: tb/tb_exception_vector_fetch.sv
// Directed bench for exception_vector_fetch: one instance at MEM_LATENCY=1 and one at 3,
// each fed by a memory model that honours its read latency.
module tb_exception_vector_fetch;

  logic        clk;
  logic        reset;
  logic        exc_opcode, exc_ovf, exc_div0;
  logic [31:0] pc_in;

  logic [31:0] mem1, mem3;
  logic [2:0]  addr_sel1, addr_sel3;
  logic        epc_write1, epc_write3, pc_write1, pc_write3;
  logic        busy1, busy3, exc_ack1, exc_ack3;
  logic [31:0] epc_value1, epc_value3, pc_value1, pc_value3;

  logic [2:0]  a1, s1, s2, s3;
  logic [6:0]  out1, out3;

  int pass_cnt = 0;
  int total_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exception_vector_fetch #(.MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_data_in(mem1),
    .addr_sel(addr_sel1), .epc_write(epc_write1), .epc_value(epc_value1),
    .pc_write(pc_write1), .pc_value(pc_value1), .busy(busy1), .exc_ack(exc_ack1)
  );

  exception_vector_fetch #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_data_in(mem3),
    .addr_sel(addr_sel3), .epc_write(epc_write3), .epc_value(epc_value3),
    .pc_write(pc_write3), .pc_value(pc_value3), .busy(busy3), .exc_ack(exc_ack3)
  );

  function automatic logic [31:0] mem_rd(input logic [2:0] a);
    case (a)
      3'b010:  mem_rd = 32'h1234_5677;
      3'b011:  mem_rd = 32'hABCD_EF9C;
      3'b100:  mem_rd = 32'hFFFF_FF20;
      default: mem_rd = 32'hCCCC_CC11;
    endcase
  endfunction

  // Memory returns data for an address that has been stable for MEM_LATENCY cycles.
  always_ff @(posedge clk) begin
    a1 <= addr_sel1;
    s1 <= addr_sel3;
    s2 <= s1;
    s3 <= s2;
  end

  assign mem1 = mem_rd(a1);
  assign mem3 = mem_rd(s3);
  assign out1 = {busy1, addr_sel1, epc_write1, pc_write1, exc_ack1};
  assign out3 = {busy3, addr_sel3, epc_write3, pc_write3, exc_ack3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // exp = {busy, addr_sel[2:0], epc_write, pc_write, exc_ack}
  task automatic expect_out(input string tag, input logic [6:0] exp, input bit use3);
    @(negedge clk);
    check(tag, use3 ? {25'b0, out3} : {25'b0, out1}, {25'b0, exp});
  endtask

  task automatic clear_reqs();
    exc_opcode = 1'b0;
    exc_ovf    = 1'b0;
    exc_div0   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_reqs();
    pc_in = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_outs", {25'b0, out1}, 32'h0);
    check("reset_epc", epc_value1, 32'h0);
    check("reset_pcv", pc_value1, 32'h0);
    reset = 1'b0;
    expect_out("idle_quiet", 7'b0_000_000, 1'b0);

    // 1) overflow: vector 254, handler byte 0x9C
    exc_ovf = 1'b1;
    pc_in   = 32'h40;
    expect_out("t1_accept", 7'b1_000_000, 1'b0);
    check("t1_epc", epc_value1, 32'h3C);
    clear_reqs();
    expect_out("t1_req", 7'b1_011_100, 1'b0);
    expect_out("t1_capture", 7'b1_011_000, 1'b0);
    expect_out("t1_done", 7'b1_000_011, 1'b0);
    check("t1_pcv", pc_value1, 32'h9C);
    expect_out("t1_idle", 7'b0_000_000, 1'b0);
    check("t1_pcv_hold", pc_value1, 32'h9C);

    // 2) all three at once: opcode wins
    exc_opcode = 1'b1;
    exc_ovf    = 1'b1;
    exc_div0   = 1'b1;
    pc_in      = 32'h100;
    expect_out("t2_accept", 7'b1_000_000, 1'b0);
    check("t2_epc", epc_value1, 32'hFC);
    clear_reqs();
    expect_out("t2_req", 7'b1_010_100, 1'b0);
    expect_out("t2_capture", 7'b1_010_000, 1'b0);
    expect_out("t2_done", 7'b1_000_011, 1'b0);
    check("t2_pcv", pc_value1, 32'h77);
    expect_out("t2_idle", 7'b0_000_000, 1'b0);
    expect_out("t2_no_2nd_ack", 7'b0_000_000, 1'b0);

    // 3) one-cycle div0 pulse, upper memory bits discarded
    exc_div0 = 1'b1;
    pc_in    = 32'h8;
    expect_out("t3_accept", 7'b1_000_000, 1'b0);
    clear_reqs();
    expect_out("t3_req", 7'b1_100_100, 1'b0);
    expect_out("t3_capture", 7'b1_100_000, 1'b0);
    expect_out("t3_done", 7'b1_000_011, 1'b0);
    check("t3_pcv", pc_value1, 32'h20);
    expect_out("t3_idle", 7'b0_000_000, 1'b0);

    // 4) ovf raised mid-sequence of div0 and dropped before idle: ignored
    exc_div0 = 1'b1;
    pc_in    = 32'h200;
    expect_out("t4_accept", 7'b1_000_000, 1'b0);
    clear_reqs();
    expect_out("t4_req", 7'b1_100_100, 1'b0);
    exc_ovf = 1'b1;
    expect_out("t4_capture", 7'b1_100_000, 1'b0);
    expect_out("t4_done", 7'b1_000_011, 1'b0);
    exc_ovf = 1'b0;
    expect_out("t4_idle", 7'b0_000_000, 1'b0);
    expect_out("t4_no_restart", 7'b0_000_000, 1'b0);
    check("t4_epc", epc_value1, 32'h1FC);

    // 5) reset during CAPTURE aborts asynchronously
    exc_ovf = 1'b1;
    pc_in   = 32'h44;
    expect_out("t5_accept", 7'b1_000_000, 1'b0);
    clear_reqs();
    expect_out("t5_req", 7'b1_011_100, 1'b0);
    expect_out("t5_capture", 7'b1_011_000, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("t5_async_outs", {25'b0, out1}, 32'h0);
    check("t5_async_epc", epc_value1, 32'h0);
    check("t5_async_pcv", pc_value1, 32'h0);
    #1 reset = 1'b0;
    expect_out("t5_no_pcw", 7'b0_000_000, 1'b0);
    expect_out("t5_still_idle", 7'b0_000_000, 1'b0);
    exc_ovf = 1'b1;
    pc_in   = 32'h80;
    expect_out("t5r_accept", 7'b1_000_000, 1'b0);
    check("t5r_epc", epc_value1, 32'h7C);
    clear_reqs();
    expect_out("t5r_req", 7'b1_011_100, 1'b0);
    expect_out("t5r_capture", 7'b1_011_000, 1'b0);
    expect_out("t5r_done", 7'b1_000_011, 1'b0);
    check("t5r_pcv", pc_value1, 32'h9C);

    // 6) MEM_LATENCY=3 instance, EPC wraps below zero
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_reset_pcv", pc_value3, 32'h0);
    exc_div0 = 1'b1;
    pc_in    = 32'h0;
    expect_out("t6_accept", 7'b1_000_000, 1'b1);
    check("t6_epc", epc_value3, 32'hFFFF_FFFC);
    clear_reqs();
    expect_out("t6_req0", 7'b1_100_100, 1'b1);
    expect_out("t6_req1", 7'b1_100_000, 1'b1);
    expect_out("t6_req2", 7'b1_100_000, 1'b1);
    expect_out("t6_capture", 7'b1_100_000, 1'b1);
    expect_out("t6_done", 7'b1_000_011, 1'b1);
    check("t6_pcv", pc_value3, 32'h20);
    expect_out("t6_idle", 7'b0_000_000, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
